// File: rtl/rr_cons_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_cons_arbiter_if
//  Description : Bundle of producer-side and consumer-side signals shared
//                by the round-robin arbiter.
//                  master : producers and consumer (drive requests, observe
//                           grants and the forwarded beat)
//                  slave  : the arbiter itself
//  Ports       : src_val  [NUM_SRC]     per-source valid
//                src_data [NUM_SRC*DW]  packed source data, src i at [i*DW +: DW]
//                src_rdy  [NUM_SRC]     one-hot (or zero) same-cycle grant
//                val                    registered valid to consumer
//                data     [DW]          registered data to consumer
//                src_id   [clog2(NUM_SRC)] source index of current beat
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_cons_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 8
);
  localparam int IW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]    src_val;
  logic [NUM_SRC*DW-1:0] src_data;
  logic [NUM_SRC-1:0]    src_rdy;
  logic                  val;
  logic [DW-1:0]         data;
  logic [IW-1:0]         src_id;

  modport master (
    output src_val,
    output src_data,
    input  src_rdy,
    input  val,
    input  data,
    input  src_id
  );

  modport slave (
    input  src_val,
    input  src_data,
    output src_rdy,
    output val,
    output data,
    output src_id
  );
endinterface
`default_nettype wire

// File: rtl/rr_cons_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_cons_arbiter
//  Description : Round-robin arbiter letting NUM_SRC producers share one
//                val/data consumer port. The grant (src_rdy) is returned in
//                the same cycle as the request; the winning beat reaches the
//                consumer through one register stage.
//  Options     : ARB_LOCK_EN - when defined, a granted source keeps the
//                grant for up to QUANTUM consecutive beats while it keeps
//                src_val high. When undefined every cycle re-arbitrates.
//  Ports       : clk    clock, all state on rising edge
//                rst_b  asynchronous active-low reset
//                bus    rr_cons_arbiter_if.slave (src_val/src_data/src_rdy,
//                       val/data/src_id); NUM_SRC and DW must match the
//                       interface instance
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_cons_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 8,
  parameter int QUANTUM = 4
) (
  input wire logic          clk,
  input wire logic          rst_b,
  rr_cons_arbiter_if.slave  bus
);

  localparam int            IW       = $clog2(NUM_SRC);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SRC - 1);

  // ptr holds the most recent winner. While locked, the owner is always the
  // most recent winner, so ptr doubles as the lock owner.
  logic [IW-1:0]      ptr;
  logic [NUM_SRC-1:0] grant;
  logic [IW-1:0]      win_idx;
  logic               xfer;
  logic               hold_owner;

  logic               out_val;
  logic [DW-1:0]      out_data;
  logic [IW-1:0]      out_id;

`ifdef ARB_LOCK_EN
  localparam int            CW        = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] QUANTUM_C = CW'(QUANTUM);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } lock_state_t;

  lock_state_t   state;
  logic [CW-1:0] cnt;

  // If the owner has dropped its request the lock releases this very cycle
  // and normal search (from owner+1) applies.
  assign hold_owner = (state == LOCK) && bus.src_val[ptr];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (hold_owner) begin
      if ((cnt + 1'b1) == QUANTUM_C) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (xfer && (QUANTUM > 1)) begin
      state <= LOCK;
      cnt   <= CW'(1);
    end else begin
      state <= IDLE;
      cnt   <= '0;
    end
  end
`else
  assign hold_owner = 1'b0;
`endif

  // Round-robin search. Offsets are scanned from farthest to nearest so the
  // nearest requester after ptr overwrites any earlier candidate and wins.
  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    grant   = '0;
    win_idx = ptr;
    idx     = 0;
    sel     = '0;
    if (hold_owner) begin
      grant[ptr] = 1'b1;
    end else begin
      for (int k = NUM_SRC; k >= 1; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_SRC) begin
          idx = idx - NUM_SRC;
        end
        sel = IW'(idx);
        if (bus.src_val[sel]) begin
          grant      = '0;
          grant[sel] = 1'b1;
          win_idx    = sel;
        end
      end
    end
  end

  // Grants are forced low while reset is asserted, independent of the clock.
  assign bus.src_rdy = grant & {NUM_SRC{rst_b}};
  assign xfer        = |bus.src_rdy;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr      <= LAST_IDX;
      out_val  <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
    end else if (xfer) begin
      ptr      <= win_idx;
      out_val  <= 1'b1;
      out_data <= bus.src_data[int'(win_idx)*DW +: DW];
      out_id   <= win_idx;
    end else begin
      out_val  <= 1'b0;
    end
  end

  assign bus.val    = out_val;
  assign bus.data   = out_data;
  assign bus.src_id = out_id;

endmodule
`default_nettype wire
